vga_timing_gen: RTL and testbench

- Parametrised VGA timing and pixel-output stage; successor to the fixed 640x480 top-level display path.
- Derives a pixel strobe from the system clock and generates hsync/vsync and pixel coordinates.
- Delays sync and blanking to match a pixel source with configurable latency, and drives blanked RGB.
- Sits between the pixel source (framebuffer or pattern logic) and the board VGA DAC pins.

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/vga_timing_gen_pix_strobe.sv | 51 +++++
 rtl/vga_timing_gen.sv | 247 ++++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA timing path.
//   - Default 640x480@60 timing (25 MHz pixel clock from a 100 MHz system clock)
//   - h_total / v_total helpers that sum the four segments of a line / frame
//   - Colour-bar constants used by the optional test pattern
//     (compiled in when VGA_TEST_PATTERN_EN is defined)
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;

   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int VGA_CLK_DIV  = 4;
   localparam int VGA_PIPE_LAT = 1;
   localparam int VGA_COLOR_W  = 12;

   // Colour bars: eight equal-width bars, bar 0 white down to bar 7 black.
   // The colour index is 7 - bar; index bit2/bit1/bit0 drive R/G/B.
   localparam int         NUM_BARS      = 8;
   localparam logic [2:0] BAR_IDX_WHITE = 3'd7;
   localparam logic [2:0] BAR_IDX_BLACK = 3'd0;

   function automatic int h_total(input int active, input int fp,
                                  input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(input int active, input int fp,
                                  input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_pix_strobe.sv
// -----------------------------------------------------------------------------
// vga_pix_strobe
// Divides the system clock down to a one-clk pixel strobe.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   enable   in   run the divider; low clears it and suppresses the strobe
//   pix_en   out  high for one clk while the divider sits at CLK_DIV-1
// With CLK_DIV = 1 the strobe is high on every enabled clk.
// -----------------------------------------------------------------------------
module vga_pix_strobe
   import vga_pkg::*;
#(
   parameter int CLK_DIV = VGA_CLK_DIV
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   output logic pix_en
);

   // A 1-bit counter is kept for CLK_DIV = 1 so the vector is never zero-width.
   localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div;
   logic [DW-1:0] div_next;

   always_comb begin
      div_next = div + 1'b1;
      if (div == DIV_LAST) begin
         div_next = '0;
      end
   end

   // pix_en is registered alongside the counter so it is exactly high for the
   // clk in which div holds DIV_LAST, and is glitch-free at the output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div    <= '0;
         pix_en <= 1'b0;
      end else if (!enable) begin
         div    <= '0;
         pix_en <= 1'b0;
      end else begin
         div    <= div_next;
         pix_en <= (div_next == DIV_LAST);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA timing generator and pixel output stage. Produces pixel
// coordinates for an upstream pixel source, then delays sync and blanking so
// they line up with pixel data that arrives PIPE_LAT pixel ticks after its
// coordinates, and drives registered, blanked RGB toward the DAC pins.
//
// Ports:
//   clk          in   system clock (100 MHz nominal)
//   reset_n      in   asynchronous active-low reset
//   enable       in   run timing; low parks the block idle at the frame origin
//   pixel_in     in   COLOR_W pixel data, valid PIPE_LAT ticks after its x/y
//   test_mode    in   (VGA_TEST_PATTERN_EN only) replace pixel_in with bars
//   pix_en       out  one-clk pixel strobe
//   x, y         out  pixel / line counters
//   line_start   out  strobe on the tick where x == 0
//   frame_start  out  strobe on the tick where x == 0 and y == 0
//   hsync, vsync out  registered syncs, polarity HSYNC_POL / VSYNC_POL
//   de           out  registered data-enable, aligned with rgb
//   rgb          out  registered pixel, 0 outside the active area
//   frame_count  out  completed frames, wraps modulo 2^16
//
// Optional feature macro: VGA_TEST_PATTERN_EN adds test_mode and an internal
// eight-bar colour pattern generated from the delayed x coordinate.
// COLOR_W must be a multiple of 3 (equal R/G/B channel widths).
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE  = VGA_H_ACTIVE,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_ACTIVE  = VGA_V_ACTIVE,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP,
   parameter int CLK_DIV   = VGA_CLK_DIV,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int PIPE_LAT  = VGA_PIPE_LAT,
   parameter int COLOR_W   = VGA_COLOR_W,
   localparam int H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam int V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int XW       = $clog2(H_TOTAL),
   localparam int YW       = $clog2(V_TOTAL)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic [COLOR_W-1:0] pixel_in,
`ifdef VGA_TEST_PATTERN_EN
   input  logic               test_mode,
`endif
   output logic               pix_en,
   output logic [XW-1:0]      x,
   output logic [YW-1:0]      y,
   output logic               line_start,
   output logic               frame_start,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [COLOR_W-1:0] rgb,
   output logic [15:0]        frame_count
);

   localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
   localparam logic          HS_ON  = (HSYNC_POL != 0);
   localparam logic          VS_ON  = (VSYNC_POL != 0);

   // ---------------------------------------------------------------- strobe
   vga_pix_strobe #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_strobe (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .pix_en  (pix_en)
   );

   // -------------------------------------------------------------- counters
   logic x_wrap;
   logic y_wrap;

   assign x_wrap = (x == X_LAST);
   assign y_wrap = (y == Y_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x           <= '0;
         y           <= '0;
         frame_count <= '0;
      end else if (!enable) begin
         // frame_count deliberately holds across an idle period.
         x <= '0;
         y <= '0;
      end else if (pix_en) begin
         if (x_wrap) begin
            x <= '0;
            if (y_wrap) begin
               y           <= '0;
               frame_count <= frame_count + 16'd1;
            end else begin
               y <= y + 1'b1;
            end
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   // Qualified with pix_en so both are single-clk strobes and read 0 in reset.
   assign line_start  = pix_en && (x == '0);
   assign frame_start = line_start && (y == '0);

   // ------------------------------------------------------ raw timing terms
   // Compared at 32 bits: ACTIVE+FP+SYNC can equal H_TOTAL when the back
   // porch is zero, which does not fit in XW bits.
   logic [31:0] x_ext;
   logic [31:0] y_ext;
   logic        hs_raw;
   logic        vs_raw;
   logic        de_raw;

   assign x_ext  = 32'(x);
   assign y_ext  = 32'(y);
   assign hs_raw = (x_ext >= 32'(H_ACTIVE + H_FP)) &&
                   (x_ext <  32'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_raw = (y_ext >= 32'(V_ACTIVE + V_FP)) &&
                   (y_ext <  32'(V_ACTIVE + V_FP + V_SYNC));
   assign de_raw = (x_ext < 32'(H_ACTIVE)) && (y_ext < 32'(V_ACTIVE));

   // ------------------------------------------------------------ delay line
   // Sync terms travel as active-high flags; polarity is applied only at the
   // output register so a cleared pipeline always means "inactive".
   logic hs_d;
   logic vs_d;
   logic de_d;
`ifdef VGA_TEST_PATTERN_EN
   logic [XW-1:0] x_d;
`endif

   if (PIPE_LAT > 0) begin : g_dly
      logic [PIPE_LAT-1:0] hs_sr;
      logic [PIPE_LAT-1:0] vs_sr;
      logic [PIPE_LAT-1:0] de_sr;
`ifdef VGA_TEST_PATTERN_EN
      logic [XW-1:0]       x_sr [PIPE_LAT];
`endif

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            hs_sr <= '0;
            vs_sr <= '0;
            de_sr <= '0;
`ifdef VGA_TEST_PATTERN_EN
            for (int i = 0; i < PIPE_LAT; i++) x_sr[i] <= '0;
`endif
         end else if (!enable) begin
            hs_sr <= '0;
            vs_sr <= '0;
            de_sr <= '0;
`ifdef VGA_TEST_PATTERN_EN
            for (int i = 0; i < PIPE_LAT; i++) x_sr[i] <= '0;
`endif
         end else if (pix_en) begin
            // The cast drops the oldest bit, shifting the new term into bit 0.
            hs_sr <= PIPE_LAT'({hs_sr, hs_raw});
            vs_sr <= PIPE_LAT'({vs_sr, vs_raw});
            de_sr <= PIPE_LAT'({de_sr, de_raw});
`ifdef VGA_TEST_PATTERN_EN
            x_sr[0] <= x;
            for (int i = 1; i < PIPE_LAT; i++) x_sr[i] <= x_sr[i-1];
`endif
         end
      end

      assign hs_d = hs_sr[PIPE_LAT-1];
      assign vs_d = vs_sr[PIPE_LAT-1];
      assign de_d = de_sr[PIPE_LAT-1];
`ifdef VGA_TEST_PATTERN_EN
      assign x_d  = x_sr[PIPE_LAT-1];
`endif
   end else begin : g_nodly
      assign hs_d = hs_raw;
      assign vs_d = vs_raw;
      assign de_d = de_raw;
`ifdef VGA_TEST_PATTERN_EN
      assign x_d  = x;
`endif
   end

   // -------------------------------------------------------- pixel source
   logic [COLOR_W-1:0] pix_src;

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE / NUM_BARS > 0) ? (H_ACTIVE / NUM_BARS) : 1;
   localparam int CH_W  = COLOR_W / 3;

   // Bar index from the delayed x, so the bars line up with de. Anything
   // past the eighth bar (H_ACTIVE not a multiple of 8) is shown black.
   function automatic logic [COLOR_W-1:0] bar_colour(input logic [XW-1:0] xp);
      logic [31:0] bar;
      logic [2:0]  idx;
      bar = 32'(xp) / 32'(BAR_W);
      if (bar >= 32'(NUM_BARS)) begin
         idx = BAR_IDX_BLACK;
      end else begin
         idx = BAR_IDX_WHITE - bar[2:0];
      end
      return {{CH_W{idx[2]}}, {CH_W{idx[1]}}, {CH_W{idx[0]}}};
   endfunction

   always_comb begin
      pix_src = pixel_in;
      if (test_mode) begin
         pix_src = bar_colour(x_d);
      end
   end
`else
   always_comb begin
      pix_src = pixel_in;
   end
`endif

   // ------------------------------------------------------ output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hsync <= ~HS_ON;
         vsync <= ~VS_ON;
         de    <= 1'b0;
         rgb   <= '0;
      end else if (!enable) begin
         hsync <= ~HS_ON;
         vsync <= ~VS_ON;
         de    <= 1'b0;
         rgb   <= '0;
      end else if (pix_en) begin
         hsync <= hs_d ? HS_ON : ~HS_ON;
         vsync <= vs_d ? VS_ON : ~VS_ON;
         de    <= de_d;
         rgb   <= de_d ? pix_src : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

`define CHK(TAG, OBS, EXP) \
   begin \
      n_assert++; \
      assert ((OBS) === (EXP)) else begin \
         n_fail++; \
         $error("FAIL %s: observed 'h%0h expected 'h%0h", TAG, (OBS), (EXP)); \
      end \
   end

   // Instance A: default 640x480 timing, CLK_DIV=4, PIPE_LAT=1
   logic        a_rst_n, a_en, a_test_mode;
   logic [11:0] a_pixel_in;
   logic        a_pix_en, a_line_start, a_frame_start, a_hsync, a_vsync, a_de;
   logic [9:0]  a_x, a_y;
   logic [11:0] a_rgb;
   logic [15:0] a_frame_count;

   // Instance B: tiny 8/2/2/2 x 4/1/1/1 timing, CLK_DIV=1, PIPE_LAT=3
   logic        b_rst_n, b_en, b_test_mode;
   logic [11:0] b_pixel_in;
   logic        b_pix_en, b_line_start, b_frame_start, b_hsync, b_vsync, b_de;
   logic [3:0]  b_x;
   logic [2:0]  b_y;
   logic [11:0] b_rgb;
   logic [15:0] b_frame_count;

   vga_timing_gen #(
      .CLK_DIV  (4),
      .PIPE_LAT (1),
      .COLOR_W  (12)
   ) dut_a (
      .clk         (clk),
      .reset_n     (a_rst_n),
      .enable      (a_en),
      .pixel_in    (a_pixel_in),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode   (a_test_mode),
`endif
      .pix_en      (a_pix_en),
      .x           (a_x),
      .y           (a_y),
      .line_start  (a_line_start),
      .frame_start (a_frame_start),
      .hsync       (a_hsync),
      .vsync       (a_vsync),
      .de          (a_de),
      .rgb         (a_rgb),
      .frame_count (a_frame_count)
   );

   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .CLK_DIV  (1),
      .PIPE_LAT (3),
      .COLOR_W  (12)
   ) dut_b (
      .clk         (clk),
      .reset_n     (b_rst_n),
      .enable      (b_en),
      .pixel_in    (b_pixel_in),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode   (b_test_mode),
`endif
      .pix_en      (b_pix_en),
      .x           (b_x),
      .y           (b_y),
      .line_start  (b_line_start),
      .frame_start (b_frame_start),
      .hsync       (b_hsync),
      .vsync       (b_vsync),
      .de          (b_de),
      .rgb         (b_rgb),
      .frame_count (b_frame_count)
   );

   // Small config: H_TOTAL = 14, V_TOTAL = 7; tick c counts from the first strobe.
   function automatic int bx(input int c);
      return c % 14;
   endfunction
   function automatic int by(input int c);
      return (c / 14) % 7;
   endfunction
   function automatic logic b_hs(input int c);
      return (c >= 0) && (bx(c) >= 10) && (bx(c) < 12);
   endfunction
   function automatic logic b_vs(input int c);
      return (c >= 0) && (by(c) == 5);
   endfunction
   function automatic logic b_dr(input int c);
      return (c >= 0) && (bx(c) < 8) && (by(c) < 4);
   endfunction
   function automatic logic [11:0] b_pix(input int xv);
      return 12'hA05 | (12'(xv) << 4);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_next_pix(output int clks);
      clks = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         clks++;
         if (a_pix_en) break;
      end
      `CHK("a_pix_en_seen", a_pix_en, 1'b1)
   endtask

   int n;
   int total_clks;
   int bad_period;
   int hs_first;
   int hs_cnt;
   int vs_cnt;
   int de_first;
   int de_last;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      a_rst_n = 1'b0; a_en = 1'b0; a_test_mode = 1'b0; a_pixel_in = 12'hABC;
      b_rst_n = 1'b0; b_en = 1'b0; b_test_mode = 1'b0; b_pixel_in = 12'hEEE;
`ifdef VGA_TEST_PATTERN_EN
      a_test_mode = 1'b1;
`endif
      repeat (3) tick();

      // ---- reset state
      `CHK("a_rst_hsync", a_hsync, 1'b1)
      `CHK("a_rst_vsync", a_vsync, 1'b1)
      `CHK("a_rst_rgb", a_rgb, 12'h000)
      `CHK("a_rst_de", a_de, 1'b0)
      `CHK("a_rst_x", a_x, 10'd0)
      `CHK("a_rst_pix_en", a_pix_en, 1'b0)
      `CHK("a_rst_frame_start", a_frame_start, 1'b0)
      `CHK("a_rst_frame_count", a_frame_count, 16'd0)
      `CHK("b_rst_hsync", b_hsync, 1'b1)
      `CHK("b_rst_line_start", b_line_start, 1'b0)

      // ---- release A with enable high; B released but kept idle
      a_rst_n = 1'b1; a_en = 1'b1; b_rst_n = 1'b1;
      a_next_pix(n);
      `CHK("a_first_pix_clks", n, 3)
      `CHK("a_t0_x", a_x, 10'd0)
      `CHK("a_t0_y", a_y, 10'd0)
      `CHK("a_t0_frame_start", a_frame_start, 1'b1)
      `CHK("a_t0_line_start", a_line_start, 1'b1)
      `CHK("a_t0_de", a_de, 1'b0)
      `CHK("b_idle_pix_en", b_pix_en, 1'b0)
      `CHK("b_idle_x", b_x, 4'd0)

      // ---- one full line of A
      total_clks = 0; bad_period = 0;
      hs_first = -1; hs_cnt = 0; vs_cnt = 0; de_first = -1; de_last = -1;
      for (int k = 1; k <= 800; k++) begin
         a_next_pix(n);
         total_clks += n;
         if (n != 4) bad_period++;
         if (!a_hsync) begin
            if (hs_first < 0) hs_first = k;
            hs_cnt++;
         end
         if (!a_vsync) vs_cnt++;
         if (a_de) begin
            if (de_first < 0) de_first = k;
            de_last = k;
         end
         if (k == 1) begin
            `CHK("a_t1_x", a_x, 10'd1)
            `CHK("a_t1_frame_start", a_frame_start, 1'b0)
         end
         if (k == 2) begin
`ifdef VGA_TEST_PATTERN_EN
            `CHK("a_bar0_first", a_rgb, 12'hFFF)
`else
            `CHK("a_rgb_first_active", a_rgb, 12'hABC)
`endif
         end
`ifdef VGA_TEST_PATTERN_EN
         if (k == 81)  `CHK("a_bar0_last", a_rgb, 12'hFFF)
         if (k == 82)  `CHK("a_bar1_first", a_rgb, 12'hFF0)
         if (k == 561) `CHK("a_bar6_last", a_rgb, 12'h00F)
         if (k == 562) `CHK("a_bar7_first", a_rgb, 12'h000)
         if (k == 641) `CHK("a_bar7_last_de", a_de, 1'b1)
`else
         if (k == 641) `CHK("a_rgb_last_active", a_rgb, 12'hABC)
`endif
         if (k == 642) begin
            `CHK("a_rgb_blank_x640", a_rgb, 12'h000)
            `CHK("a_de_blank_x640", a_de, 1'b0)
         end
         if (k == 657) `CHK("a_hsync_before", a_hsync, 1'b1)
         if (k == 658) `CHK("a_hsync_start", a_hsync, 1'b0)
         if (k == 753) `CHK("a_hsync_last", a_hsync, 1'b0)
         if (k == 754) `CHK("a_hsync_end", a_hsync, 1'b1)
         if (k == 800) begin
            `CHK("a_wrap_x", a_x, 10'd0)
            `CHK("a_wrap_y", a_y, 10'd1)
            `CHK("a_wrap_line_start", a_line_start, 1'b1)
            `CHK("a_wrap_frame_start", a_frame_start, 1'b0)
         end
      end
      `CHK("a_line_period_clks", total_clks, 3200)
      `CHK("a_pix_period_errors", bad_period, 0)
      `CHK("a_hsync_first_tick", hs_first, 658)
      `CHK("a_hsync_width", hs_cnt, 96)
      `CHK("a_vsync_low_line0", vs_cnt, 0)
      `CHK("a_de_first_tick", de_first, 2)
      `CHK("a_de_last_tick", de_last, 641)
      `CHK("a_frame_count_line1", a_frame_count, 16'd0)

      // ---- small config: counters, wraps, alignment with PIPE_LAT=3
      b_en = 1'b1;
      tick();
      for (int c = 0; c <= 113; c++) begin
         `CHK("b_pix_en", b_pix_en, 1'b1)
         `CHK("b_x", b_x, 4'(bx(c)))
         `CHK("b_y", b_y, 3'(by(c)))
         `CHK("b_frame_count", b_frame_count, 16'(c / 98))
         `CHK("b_line_start", b_line_start, (bx(c) == 0))
         `CHK("b_frame_start", b_frame_start, (bx(c) == 0) && (by(c) == 0))
         `CHK("b_hsync", b_hsync, ~b_hs(c - 4))
         `CHK("b_vsync", b_vsync, ~b_vs(c - 4))
         `CHK("b_de", b_de, b_dr(c - 4))
         `CHK("b_rgb", b_rgb, (b_dr(c - 4) ? b_pix(bx(c - 4)) : 12'h000))
         if (c == 97) begin
            `CHK("b_last_x", b_x, 4'd13)
            `CHK("b_last_y", b_y, 3'd6)
         end
         if (c == 98) begin
            `CHK("b_fwrap_frame_count", b_frame_count, 16'd1)
            `CHK("b_fwrap_frame_start", b_frame_start, 1'b1)
         end
         b_pixel_in = (c >= 3) ? b_pix(bx(c - 3)) : 12'hEEE;
         if (c < 113) tick();
      end
      `CHK("b_hsync_active_before_drop", b_hsync, 1'b0)

      // ---- enable dropped mid-line
      b_en = 1'b0;
      tick();
      `CHK("b_dis_x", b_x, 4'd0)
      `CHK("b_dis_y", b_y, 3'd0)
      `CHK("b_dis_pix_en", b_pix_en, 1'b0)
      `CHK("b_dis_hsync", b_hsync, 1'b1)
      `CHK("b_dis_de", b_de, 1'b0)
      `CHK("b_dis_rgb", b_rgb, 12'h000)
      `CHK("b_dis_frame_count_hold", b_frame_count, 16'd1)
      tick();
      `CHK("b_dis_x_hold", b_x, 4'd0)

      // ---- re-enable: first strobe is the frame origin
      b_en = 1'b1;
      tick();
      `CHK("b_reen_pix_en", b_pix_en, 1'b1)
      `CHK("b_reen_x", b_x, 4'd0)
      `CHK("b_reen_frame_start", b_frame_start, 1'b1)
      repeat (14) tick();
      `CHK("b_t14_x", b_x, 4'd0)
      `CHK("b_t14_y", b_y, 3'd1)
      `CHK("b_t14_hsync", b_hsync, 1'b0)

      // ---- asynchronous reset in the middle of an hsync pulse
      #2;
      b_rst_n = 1'b0;
      #1;
      `CHK("b_arst_hsync", b_hsync, 1'b1)
      `CHK("b_arst_vsync", b_vsync, 1'b1)
      `CHK("b_arst_x", b_x, 4'd0)
      `CHK("b_arst_y", b_y, 3'd0)
      `CHK("b_arst_pix_en", b_pix_en, 1'b0)
      `CHK("b_arst_frame_count", b_frame_count, 16'd0)
      tick();
      `CHK("b_arst_hold_hsync", b_hsync, 1'b1)
      b_rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
